soc_system_st_ready_latency_adapter: RTL and testbench

//   Parametrised Avalon-ST timing adapter that replaces pass-through ready/valid wiring with a buffered adapter.
//   - Converts an upstream source with ready latency IN_READY_LATENCY (0..3) to a downstream ready-latency-0 sink.
//   - Absorbs downstream backpressure in a DEPTH-entry FIFO. Upstream is throttled through in_ready.
//   - Protocol violations are dropped beats; they are flagged, never silently corrupted.
//   - Sits between HPS-side stream masters and fabric stream sinks in the soc_system interconnect.

---
 rtl/soc_st_ta_pkg.sv | 23 ++
 rtl/soc_st_ta_fifo.sv | 72 +++++++
 rtl/soc_system_st_ready_latency_adapter.sv | 125 ++++++++++++
 tb/tb_soc_system_st_ready_latency_adapter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_st_ta_pkg.sv
// Shared widths, beat layout and sizing helpers for the ready-latency adapter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package soc_st_ta_pkg;

    localparam int DROP_CNT_W = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CH_W   = 1;

    typedef struct packed {
        logic [DEF_CH_W-1:0]   channel;
        logic [DEF_DATA_W-1:0] data;
    } beat_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/soc_st_ta_fifo.sv
// DEPTH-entry circular beat buffer with occupancy count; storage cleared on reset.
// Latency: a push is visible on rdata the cycle after the write edge.
// Backpressure: push is ignored when full, pop is ignored when empty.
module soc_st_ta_fifo
    import soc_st_ta_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int PTR_W = ptr_w(DEPTH),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] used
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] used_q, used_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        push_ok  = push && (used_q != CNT_W'(DEPTH));
        pop_ok   = pop && (used_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_ok && !pop_ok) begin
            used_d = used_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            used_d = used_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign used  = used_q;

endmodule

// File: rtl/soc_system_st_ready_latency_adapter.sv
// Avalon-ST adapter: upstream ready latency 0..3 to a ready-latency-0 sink; SOC_ST_TA_DROP_COUNT_EN adds drop_count.
// Latency: one cycle minimum from accepted beat to out_valid, no bypass.
// Backpressure: registered in_ready reserves room for every granted beat; unpermitted beats are dropped and flagged.
module soc_system_st_ready_latency_adapter
    import soc_st_ta_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int CHANNEL_WIDTH    = 1,
    parameter int DEPTH            = 4,
    parameter int IN_READY_LATENCY = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [CHANNEL_WIDTH-1:0] in_channel,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    input  logic                     out_ready,
    output logic                     overflow
`ifdef SOC_ST_TA_DROP_COUNT_EN
    ,
    output logic [DROP_CNT_W-1:0]    drop_count
`endif
);

    localparam int CNT_W  = cnt_w(DEPTH);
    localparam int BEAT_W = DATA_WIDTH + CHANNEL_WIDTH;

    logic              in_ready_q, in_ready_d;
    logic              overflow_q, overflow_d;
    logic              permitted, push, pop;
    logic [CNT_W-1:0]  used, used_next, inflight_next;
    logic [BEAT_W-1:0] rdata;

    // Grants older than the latency window have either delivered or expired.
    if (IN_READY_LATENCY == 0) begin : g_rl0
        assign permitted     = in_ready_q;
        assign inflight_next = '0;
    end else begin : g_rln
        logic [IN_READY_LATENCY-1:0] rdy_hist_q, rdy_hist_d;

        always_comb begin
            rdy_hist_d = IN_READY_LATENCY'({rdy_hist_q, in_ready_q});
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rdy_hist_q <= '0;
            end else begin
                rdy_hist_q <= rdy_hist_d;
            end
        end

        assign permitted     = rdy_hist_q[IN_READY_LATENCY-1];
        assign inflight_next = CNT_W'($countones(rdy_hist_d));
    end

    soc_st_ta_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   ({in_channel, in_data}),
        .rdata   (rdata),
        .used    (used)
    );

    assign out_valid = (used != '0);

    always_comb begin
        push      = in_valid && permitted;
        pop       = out_valid && out_ready;
        used_next = used;
        if (push && !pop) begin
            used_next = used + CNT_W'(1);
        end else if (!push && pop) begin
            used_next = used - CNT_W'(1);
        end
        in_ready_d = ({1'b0, used_next} + {1'b0, inflight_next}) < (CNT_W + 1)'(DEPTH);
        overflow_d = overflow_q || (in_valid && !permitted);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_ready_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            in_ready_q <= in_ready_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef SOC_ST_TA_DROP_COUNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_valid && !permitted && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    assign in_ready    = in_ready_q;
    assign overflow    = overflow_q;
    assign out_data    = rdata[DATA_WIDTH-1:0];
    assign out_channel = rdata[BEAT_W-1:DATA_WIDTH];

endmodule

// File: tb/tb_soc_system_st_ready_latency_adapter.sv
// Bench for the ready-latency adapter: three instances with ready latency 0, 1 and 2, DEPTH 4.
module tb_soc_system_st_ready_latency_adapter;
    import soc_st_ta_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid    [3];
    logic [7:0] in_data     [3];
    logic [0:0] in_channel  [3];
    logic       in_ready    [3];
    logic       out_valid   [3];
    logic [7:0] out_data    [3];
    logic [0:0] out_channel [3];
    logic       out_ready   [3];
    logic       overflow    [3];
`ifdef SOC_ST_TA_DROP_COUNT_EN
    logic [15:0] drop_count [3];
`endif
    logic [3:0] th [3];
    beat_t      sb [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] next_dat;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        soc_system_st_ready_latency_adapter #(
            .DATA_WIDTH       (8),
            .CHANNEL_WIDTH    (1),
            .DEPTH            (4),
            .IN_READY_LATENCY (g)
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .in_valid    (in_valid[g]),
            .in_data     (in_data[g]),
            .in_channel  (in_channel[g]),
            .in_ready    (in_ready[g]),
            .out_valid   (out_valid[g]),
            .out_data    (out_data[g]),
            .out_channel (out_channel[g]),
            .out_ready   (out_ready[g]),
            .overflow    (overflow[g])
`ifdef SOC_ST_TA_DROP_COUNT_EN
            ,
            .drop_count  (drop_count[g])
`endif
        );
    end

    // Upstream view of in_ready history: bit0 is the previous cycle.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            th[g] <= {th[g][2:0], in_ready[g]};
        end
    end

    function automatic bit perm(input int g);
        if (g == 0) return in_ready[g] === 1'b1;
        return th[g][g-1] === 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One legal upstream/downstream cycle; returns the beat seen leaving and the one expected.
    task automatic step(input int g, input bit v, input bit r, output bit pushed, output bit popped,
                        output beat_t got, output beat_t exp, output bit exp_ok);
        beat_t b;
        popped      = (out_valid[g] === 1'b1) && r;
        got.data    = out_data[g];
        got.channel = out_channel[g];
        exp         = '0;
        exp_ok      = 1'b0;
        if (popped && sb.size() > 0) begin
            exp    = sb.pop_front();
            exp_ok = 1'b1;
        end
        pushed        = v && perm(g);
        in_valid[g]   = pushed;
        out_ready[g]  = r;
        in_data[g]    = next_dat;
        in_channel[g] = next_dat[0];
        if (pushed) begin
            b.data    = next_dat;
            b.channel = next_dat[0];
            sb.push_back(b);
            next_dat  = next_dat + 8'd1;
        end
        tick();
        in_valid[g]  = 1'b0;
        out_ready[g] = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) tick();
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if (out_valid[g] !== 1'b0 || out_data[g] !== 8'h00 || out_channel[g] !== 1'b0 ||
                in_ready[g] !== 1'b0 || overflow[g] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: got v=%b d=%h c=%b rdy=%b ovf=%b required all 0", g,
                         out_valid[g], out_data[g], out_channel[g], in_ready[g], overflow[g]);
            end
`ifdef SOC_ST_TA_DROP_COUNT_EN
            n_cmp++;
            if (drop_count[g] !== 16'd0) begin
                n_bad++;
                $display("FAIL reset_drop_count[%0d]: got %0d required 0", g, drop_count[g]);
            end
`endif
        end
        reset_n = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if (in_ready[g] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_release_ready[%0d]: got %b required 1", g, in_ready[g]);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_latency_rl0();
        bit pu, po, ok;
        beat_t got, exp;
        next_dat = 8'h01;
        for (int k = 0; k <= 8; k++) begin
            n_cmp++;
            if (in_ready[0] !== 1'b1 || overflow[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL t1_ready[%0d]: got rdy=%b ovf=%b required rdy=1 ovf=0", k, in_ready[0], overflow[0]);
            end
            step(0, k < 8, 1'b1, pu, po, got, exp, ok);
            if (k >= 1) begin
                n_cmp++;
                if (!po || !ok || got !== exp || got.data !== 8'(k)) begin
                    n_bad++;
                    $display("FAIL t1_out[%0d]: got v=%b d=%h required v=1 d=%h", k, po, got.data, 8'(k));
                end
            end
        end
        n_cmp++;
        if (out_valid[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_empty: got out_valid=%b required 0", out_valid[0]);
        end
    endtask

    task automatic test_fill_rl2();
        bit pu, po, ok;
        beat_t got, exp;
        int pushes = 0;
        int pops = 0;
        next_dat = 8'h20;
        for (int k = 0; k < 12; k++) begin
            step(2, 1'b1, 1'b0, pu, po, got, exp, ok);
            if (pu) pushes++;
        end
        n_cmp++;
        if (pushes != 4 || in_ready[2] !== 1'b0 || out_valid[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL t2_fill: got pushes=%0d rdy=%b v=%b required 4/0/1", pushes, in_ready[2], out_valid[2]);
        end
        for (int k = 0; k < 8; k++) begin
            step(2, 1'b0, 1'b1, pu, po, got, exp, ok);
            if (po) begin
                pops++;
                n_cmp++;
                if (!ok || got !== exp) begin
                    n_bad++;
                    $display("FAIL t2_order: got %h required %h", got, exp);
                end
            end
        end
        n_cmp++;
        if (pops != 4 || sb.size() != 0 || overflow[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL t2_drain: got pops=%0d left=%0d ovf=%b required 4/0/0", pops, sb.size(), overflow[2]);
        end
    endtask

    task automatic test_drop_rl1();
        bit pu, po, ok;
        beat_t got, exp;
        int pushes = 0;
        int pops = 0;
        next_dat = 8'h40;
        for (int k = 0; k < 10; k++) begin
            step(1, 1'b1, 1'b0, pu, po, got, exp, ok);
            if (pu) pushes++;
        end
        n_cmp++;
        if (pushes != 4 || in_ready[1] !== 1'b0 || th[1][0] !== 1'b0) begin
            n_bad++;
            $display("FAIL t3_full: got pushes=%0d rdy=%b required 4/0", pushes, in_ready[1]);
        end
        in_valid[1] = 1'b1;
        in_data[1]  = 8'hEE;
        tick();
        in_valid[1] = 1'b0;
        n_cmp++;
        if (overflow[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL t3_overflow: got %b required 1", overflow[1]);
        end
`ifdef SOC_ST_TA_DROP_COUNT_EN
        n_cmp++;
        if (drop_count[1] !== 16'd1) begin
            n_bad++;
            $display("FAIL t3_drop_count: got %0d required 1", drop_count[1]);
        end
`endif
        for (int k = 0; k < 8; k++) begin
            step(1, 1'b0, 1'b1, pu, po, got, exp, ok);
            if (po) begin
                pops++;
                n_cmp++;
                if (!ok || got !== exp) begin
                    n_bad++;
                    $display("FAIL t3_order: got %h required %h", got, exp);
                end
            end
        end
        n_cmp++;
        if (pops != 4 || out_valid[1] !== 1'b0 || overflow[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL t3_after: got pops=%0d v=%b ovf=%b required 4/0/1", pops, out_valid[1], overflow[1]);
        end
    endtask

    task automatic test_full_pop_rl0();
        bit pu, po, ok;
        beat_t got, exp;
        int pushes = 0;
        int pops = 0;
        next_dat = 8'h60;
        for (int k = 0; k < 6; k++) begin
            step(0, 1'b1, 1'b0, pu, po, got, exp, ok);
            if (pu) pushes++;
        end
        n_cmp++;
        if (pushes != 4 || in_ready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL t4_full: got pushes=%0d rdy=%b required 4/0", pushes, in_ready[0]);
        end
        step(0, 1'b0, 1'b1, pu, po, got, exp, ok);
        n_cmp++;
        if (!po || !ok || got !== exp || in_ready[0] !== 1'b1 || out_valid[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL t4_pop: got d=%h rdy=%b v=%b required d=%h rdy=1 v=1", got.data, in_ready[0], out_valid[0], exp.data);
        end
        step(0, 1'b1, 1'b1, pu, po, got, exp, ok);
        n_cmp++;
        if (!pu || !po || !ok || got !== exp || in_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL t4_push_pop: got push=%b d=%h rdy=%b required push=1 d=%h rdy=1", pu, got.data, in_ready[0], exp.data);
        end
        for (int k = 0; k < 8; k++) begin
            step(0, 1'b0, 1'b1, pu, po, got, exp, ok);
            if (po) begin
                pops++;
                n_cmp++;
                if (!ok || got !== exp) begin
                    n_bad++;
                    $display("FAIL t4_order: got %h required %h", got, exp);
                end
            end
        end
        n_cmp++;
        if (pops != 3 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL t4_used: got pops=%0d left=%0d required 3/0", pops, sb.size());
        end
    endtask

    task automatic test_random_rl2();
        bit pu, po, ok, v, r;
        beat_t got, exp;
        int pushes = 0;
        int pops = 0;
        int used_m = 0;
        next_dat = 8'h00;
        for (int cyc = 0; cyc < 60000 && pops < 10000 && n_bad < 50; cyc++) begin
            if (in_ready[2] === 1'b1) begin
                n_cmp++;
                if (used_m + int'(th[2][0]) + int'(th[2][1]) >= 4) begin
                    n_bad++;
                    $display("FAIL t5_ready_safe: got in_ready=1 with used=%0d hist=%b required 0", used_m, th[2][1:0]);
                end
            end
            n_cmp++;
            if (out_valid[2] !== (used_m != 0)) begin
                n_bad++;
                $display("FAIL t5_valid: got %b required %b", out_valid[2], used_m != 0);
            end
            v = (pushes < 10000) && ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 99) < 70) || (pushes >= 10000);
            step(2, v, r, pu, po, got, exp, ok);
            if (pu) begin
                pushes++;
                used_m++;
            end
            if (po) begin
                pops++;
                used_m--;
                n_cmp++;
                if (!ok || got !== exp) begin
                    n_bad++;
                    $display("FAIL t5_order: got %h required %h", got, exp);
                end
            end
        end
        n_cmp++;
        if (pops != 10000 || overflow[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL t5_total: got pops=%0d ovf=%b required 10000/0", pops, overflow[2]);
        end
    endtask

    task automatic test_mid_reset();
        bit pu, po, ok;
        beat_t got, exp;
        int pushes = 0;
        next_dat = 8'hA0;
        for (int k = 0; k < 3; k++) begin
            step(0, 1'b1, 1'b0, pu, po, got, exp, ok);
            if (pu) pushes++;
        end
        n_cmp++;
        if (pushes != 3 || out_valid[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL t6_queued: got pushes=%0d v=%b required 3/1", pushes, out_valid[0]);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        sb.delete();
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if (out_valid[g] !== 1'b0 || overflow[g] !== 1'b0 || in_ready[g] !== 1'b0 || out_data[g] !== 8'h00) begin
                n_bad++;
                $display("FAIL t6_reset[%0d]: got v=%b ovf=%b rdy=%b d=%h required 0/0/0/00", g,
                         out_valid[g], overflow[g], in_ready[g], out_data[g]);
            end
        end
        tick();
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if (in_ready[g] !== 1'b1 || out_valid[g] !== 1'b0) begin
                n_bad++;
                $display("FAIL t6_release[%0d]: got rdy=%b v=%b required 1/0", g, in_ready[g], out_valid[g]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            in_valid[g]   = 1'b0;
            in_data[g]    = 8'h00;
            in_channel[g] = 1'b0;
            out_ready[g]  = 1'b0;
        end
        next_dat = 8'h00;
        test_reset();
        test_latency_rl0();
        test_fill_rl2();
        test_drop_rl1();
        test_full_pop_rl0();
        test_random_rl2();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
